// File: rtl/ecc_job_scheduler.sv
// Round-robin job scheduler that serialises requester jobs onto an APB-programmed ECC engine.
// Optional WAIT-state timeout is enabled by defining ECC_JOB_SCHEDULER_TIMEOUT_EN.
module ecc_job_scheduler #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REQ         = 2,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [2*NUM_REQ-1:0]          req_ctrl,
  input  logic [2*NUM_REQ-1:0]          req_width,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_noise,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  output logic [AMBA_WORD-1:0]          PWDATA,
  input  logic                          operation_done,
  input  logic [DATA_WIDTH-1:0]         data_out,
  input  logic [1:0]                    num_of_errors,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [1:0]                    rsp_errors,
  output logic                          rsp_timeout
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t                     r_state;
  logic [IDW-1:0]             r_last;
  logic [IDW-1:0]             r_id;
  logic [1:0]                 r_ctrl;
  logic [1:0]                 r_width;
  logic [1:0]                 r_widx;
  logic [DATA_WIDTH-1:0]      r_data;
  logic [DATA_WIDTH-1:0]      r_noise;
  logic                       r_psel;
  logic                       r_penable;
  logic                       r_pwrite;
  logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
  logic [AMBA_WORD-1:0]       r_pwdata;
  logic                       r_rsp_valid;
  logic [IDW-1:0]             r_rsp_id;
  logic [DATA_WIDTH-1:0]      r_rsp_data;
  logic [1:0]                 r_rsp_errors;

  logic [1:0]                 w_ctrl_arr  [NUM_REQ];
  logic [1:0]                 w_width_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]      w_data_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]      w_noise_arr [NUM_REQ];
  logic [IDW-1:0]             w_grant;
  logic                       w_any;
  logic [IDW:0]               w_sum;
  logic [IDW-1:0]             w_cand;
  logic [1:0]                 w_next_idx;
  logic [AMBA_ADDR_WIDTH-1:0] w_next_addr;
  logic [AMBA_WORD-1:0]       w_next_wdata;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_ctrl_arr[gi]  = req_ctrl[2*gi +: 2];
    assign w_width_arr[gi] = req_width[2*gi +: 2];
    assign w_data_arr[gi]  = req_data[DATA_WIDTH*gi +: DATA_WIDTH];
    assign w_noise_arr[gi] = req_noise[DATA_WIDTH*gi +: DATA_WIDTH];
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NUM_REQ)) w_sum = w_sum - (IDW+1)'(NUM_REQ);
      w_cand = w_sum[IDW-1:0];
      if (!w_any && req_valid[w_cand]) begin
        w_grant = w_cand;
        w_any   = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && r_state == S_IDLE && w_any) req_ready[w_grant] = 1'b1;
  end

  // Register order: DATA_IN, CODEWORD_WIDTH, NOISE (full channel only), CTRL.
  always_comb begin
    w_next_idx = (r_widx == 2'd1 && r_ctrl != 2'b10) ? 2'd3 : r_widx + 2'd1;
    case (w_next_idx)
      2'd0: begin
        w_next_addr  = AMBA_ADDR_WIDTH'('h04);
        w_next_wdata = AMBA_WORD'(r_data);
      end
      2'd1: begin
        w_next_addr  = AMBA_ADDR_WIDTH'('h08);
        w_next_wdata = AMBA_WORD'(r_width);
      end
      2'd2: begin
        w_next_addr  = AMBA_ADDR_WIDTH'('h0C);
        w_next_wdata = AMBA_WORD'(r_noise);
      end
      default: begin
        w_next_addr  = AMBA_ADDR_WIDTH'('h00);
        w_next_wdata = AMBA_WORD'(r_ctrl);
      end
    endcase
  end

`ifdef ECC_JOB_SCHEDULER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          r_rsp_timeout;
  assign rsp_timeout = r_rsp_timeout;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last       <= IDW'(NUM_REQ - 1);
      r_id         <= '0;
      r_ctrl       <= '0;
      r_width      <= '0;
      r_widx       <= '0;
      r_data       <= '0;
      r_noise      <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
      r_rsp_errors <= '0;
`ifdef ECC_JOB_SCHEDULER_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_last    <= w_grant;
            r_id      <= w_grant;
            r_ctrl    <= (w_ctrl_arr[w_grant] == 2'b11) ? 2'b00 : w_ctrl_arr[w_grant];
            r_width   <= w_width_arr[w_grant];
            r_data    <= w_data_arr[w_grant];
            r_noise   <= w_noise_arr[w_grant];
            r_widx    <= 2'd0;
            r_psel    <= 1'b1;
            r_pwrite  <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= AMBA_ADDR_WIDTH'('h04);
            r_pwdata  <= AMBA_WORD'(w_data_arr[w_grant]);
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_widx == 2'd3) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_state   <= S_WAIT;
`ifdef ECC_JOB_SCHEDULER_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end else begin
            r_widx    <= w_next_idx;
            r_penable <= 1'b0;
            r_paddr   <= w_next_addr;
            r_pwdata  <= w_next_wdata;
            r_state   <= S_SETUP;
          end
        end
        S_WAIT: begin
          if (operation_done) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_data   <= data_out;
            r_rsp_errors <= num_of_errors;
            r_state      <= S_RESP;
`ifdef ECC_JOB_SCHEDULER_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
          end
`ifdef ECC_JOB_SCHEDULER_TIMEOUT_EN
          else if (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_id;
            r_rsp_data    <= '0;
            r_rsp_errors  <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
`endif
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign PSEL       = r_psel;
  assign PENABLE    = r_penable;
  assign PWRITE     = r_pwrite;
  assign PADDR      = r_paddr;
  assign PWDATA     = r_pwdata;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_errors = r_rsp_errors;

endmodule

// File: tb/tb_ecc_job_scheduler.sv
// Self-checking bench for ecc_job_scheduler: a job-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_ecc_job_scheduler;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int WD = 32;
  localparam int TO = 64;

  localparam int M_IDLE = 0;
  localparam int M_BUS  = 1;
  localparam int M_WAIT = 2;
  localparam int M_RESP = 3;

  logic                 clk;
  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [2*NR-1:0]      req_ctrl;
  logic [2*NR-1:0]      req_width;
  logic [DW*NR-1:0]     req_data;
  logic [DW*NR-1:0]     req_noise;
  logic                 PSEL, PENABLE, PWRITE;
  logic [AW-1:0]        PADDR;
  logic [WD-1:0]        PWDATA;
  logic                 operation_done;
  logic [DW-1:0]        data_out;
  logic [1:0]           num_of_errors;
  logic                 rsp_valid;
  logic [$clog2(NR)-1:0] rsp_id;
  logic [DW-1:0]        rsp_data;
  logic [1:0]           rsp_errors;
  logic                 rsp_timeout;

  ecc_job_scheduler #(
    .AMBA_WORD(WD), .AMBA_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl), .req_width(req_width),
    .req_data(req_data), .req_noise(req_noise),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_errors(rsp_errors),
    .rsp_timeout(rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [WD-1:0] d;
  } wr_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Job-level model: current phase, pending bus writes, held response fields.
  int          m_state;
  int          m_last;
  int          m_id;
  int          m_phase;
  int          m_wait;
  wr_t         m_q[$];
  int          m_rsp_id;
  logic [DW-1:0] m_rsp_data;
  logic [1:0]  m_rsp_err;
  logic        m_rsp_to;

  // Observations of the DUT, used only by literal checks.
  wr_t         apb_log[$];
  int          grant_log[$];
  int          psel_cycles;
  int          rsp_count;
  logic [NR-1:0] last_ready;
  logic        last_psel;
  int          last_rsp_id;
  logic [DW-1:0] last_rsp_data;
  logic [1:0]  last_rsp_err;
  logic        last_rsp_to;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = M_IDLE;
    m_last     = NR - 1;
    m_id       = 0;
    m_phase    = 0;
    m_wait     = 0;
    m_q.delete();
    m_rsp_id   = 0;
    m_rsp_data = '0;
    m_rsp_err  = '0;
    m_rsp_to   = 1'b0;
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= NR; k++) begin
      if (req_valid[(m_last + k) % NR]) return (m_last + k) % NR;
    end
    return -1;
  endfunction

  task automatic clear_obs();
    apb_log.delete();
    grant_log.delete();
    psel_cycles = 0;
    rsp_count   = 0;
  endtask

  task automatic compare_step();
    logic [NR-1:0] exp_ready;
    logic          bus;
    int            g;
    logic [1:0]    c;
    if (!rst) model_reset();
    bus = (m_state == M_BUS);
    exp_ready = '0;
    g = model_grant();
    if (rst && m_state == M_IDLE && g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("PSEL", PSEL, bus);
    chk("PENABLE", PENABLE, bus && m_phase == 1);
    chk("PWRITE", PWRITE, bus);
    chk("PADDR", PADDR, bus ? m_q[0].a : '0);
    chk("PWDATA", PWDATA, bus ? m_q[0].d : '0);
    chk("rsp_valid", rsp_valid, m_state == M_RESP);
    chk("rsp_id", rsp_id, m_rsp_id);
    chk("rsp_data", rsp_data, m_rsp_data);
    chk("rsp_errors", rsp_errors, m_rsp_err);
    chk("rsp_timeout", rsp_timeout, m_rsp_to);

    last_ready = req_ready;
    last_psel  = PSEL;
    if (PSEL) psel_cycles++;
    if (PSEL && PENABLE) apb_log.push_back('{PADDR, PWDATA});
    for (int i = 0; i < NR; i++) if (req_ready[i]) grant_log.push_back(i);
    if (rsp_valid) begin
      rsp_count++;
      last_rsp_id   = rsp_id;
      last_rsp_data = rsp_data;
      last_rsp_err  = rsp_errors;
      last_rsp_to   = rsp_timeout;
    end

    if (rst) begin
      case (m_state)
        M_IDLE: if (g >= 0) begin
          c = req_ctrl[2*g +: 2];
          if (c == 2'b11) c = 2'b00;
          m_q.push_back('{AW'('h04), WD'(req_data[g*DW +: DW])});
          m_q.push_back('{AW'('h08), WD'(req_width[2*g +: 2])});
          if (c == 2'b10) m_q.push_back('{AW'('h0C), WD'(req_noise[g*DW +: DW])});
          m_q.push_back('{AW'('h00), WD'(c)});
          m_id    = g;
          m_last  = g;
          m_phase = 0;
          m_state = M_BUS;
        end
        M_BUS: begin
          if (m_phase == 0) m_phase = 1;
          else begin
            void'(m_q.pop_front());
            m_phase = 0;
            if (m_q.size() == 0) begin
              m_state = M_WAIT;
              m_wait  = 0;
            end
          end
        end
        M_WAIT: begin
          if (operation_done) begin
            m_rsp_id   = m_id;
            m_rsp_data = data_out;
            m_rsp_err  = num_of_errors;
            m_rsp_to   = 1'b0;
            m_state    = M_RESP;
          end else begin
            m_wait++;
`ifdef ECC_JOB_SCHEDULER_TIMEOUT_EN
            if (m_wait == TO) begin
              m_rsp_id   = m_id;
              m_rsp_data = '0;
              m_rsp_err  = '0;
              m_rsp_to   = 1'b1;
              m_state    = M_RESP;
            end
`endif
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int st, input int lim, input string nm);
    int n;
    n = 0;
    while (m_state != st && n < lim) begin
      tick();
      n++;
    end
    if (m_state != st) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: model state %0d after %0d cycles, required %0d", nm, m_state, n, st);
    end
  endtask

  task automatic finish_job(input string nm);
    int n;
    n = 0;
    while (m_state != M_IDLE && n < 100) begin
      operation_done = (m_state == M_WAIT);
      data_out       = $urandom;
      tick();
      n++;
    end
    operation_done = 1'b0;
    if (m_state != M_IDLE) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: job not finished after %0d cycles, state %0d", nm, n, m_state);
    end
  endtask

  task automatic set_req0(input logic [1:0] c, input logic [1:0] w, input logic [DW-1:0] d,
                          input logic [DW-1:0] nz);
    req_ctrl[1:0]   = c;
    req_width[1:0]  = w;
    req_data[DW-1:0]  = d;
    req_noise[DW-1:0] = nz;
  endtask

  initial begin
    logic [DW-1:0] dB;
    int            k_at;
    rst = 1'b0;
    req_valid = '0; req_ctrl = '0; req_width = '0; req_data = '0; req_noise = '0;
    operation_done = 1'b0; data_out = '0; num_of_errors = '0;
    model_reset();
    clear_obs();
    @(posedge clk); #1;
    req_valid = 2'b01;
    tick();
    chk("reset_ready", last_ready, 2'b00);
    chk("reset_psel", last_psel, 1'b0);
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();

    // Mode 00 job from requester 0.
    clear_obs();
    req_valid = 2'b01;
    set_req0(2'b00, 2'b01, 32'h5A, 32'h0);
    tick();
    chk("A_ready", last_ready, 2'b01);
    req_valid = '0;
    wait_state(M_WAIT, 20, "A_wait");
    chk("A_psel_cycles", psel_cycles, 6);
    chk("A_nwrites", apb_log.size(), 3);
    if (apb_log.size() == 3) begin
      chk("A_w0_addr", apb_log[0].a, 'h04); chk("A_w0_data", apb_log[0].d, 'h5A);
      chk("A_w1_addr", apb_log[1].a, 'h08); chk("A_w1_data", apb_log[1].d, 'h1);
      chk("A_w2_addr", apb_log[2].a, 'h00); chk("A_w2_data", apb_log[2].d, 'h0);
    end
    data_out = 32'hCAFE_1234; num_of_errors = 2'd1; operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    tick();
    chk("A_rsp_count", rsp_count, 1);
    chk("A_rsp_id", last_rsp_id, 0);
    chk("A_rsp_data", last_rsp_data, 32'hCAFE_1234);
    chk("A_rsp_err", last_rsp_err, 2'd1);

    // Full-channel job carries the NOISE write.
    clear_obs();
    dB = $urandom;
    req_valid = 2'b01;
    set_req0(2'b10, 2'b10, dB, 32'h3);
    tick();
    req_valid = '0;
    wait_state(M_WAIT, 20, "B_wait");
    chk("B_psel_cycles", psel_cycles, 8);
    chk("B_nwrites", apb_log.size(), 4);
    if (apb_log.size() == 4) begin
      chk("B_w0_addr", apb_log[0].a, 'h04); chk("B_w0_data", apb_log[0].d, dB);
      chk("B_w1_addr", apb_log[1].a, 'h08); chk("B_w1_data", apb_log[1].d, 'h2);
      chk("B_w2_addr", apb_log[2].a, 'h0C); chk("B_w2_data", apb_log[2].d, 'h3);
      chk("B_w3_addr", apb_log[3].a, 'h00); chk("B_w3_data", apb_log[3].d, 'h2);
    end
    data_out = $urandom; num_of_errors = 2'd2; operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    tick();
    chk("B_rsp_err", last_rsp_err, 2'd2);

    // ctrl 11 maps to encode; done during SETUP is ignored.
    clear_obs();
    req_valid = 2'b01;
    set_req0(2'b11, 2'b11, 32'h1234_5678, 32'h0);
    tick();
    req_valid = '0;
    operation_done = 1'b1; data_out = 32'hDEAD_BEEF;
    tick();
    operation_done = 1'b0;
    wait_state(M_WAIT, 20, "C_wait");
    tick(); tick(); tick();
    chk("C_no_early_rsp", rsp_count, 0);
    chk("C_nwrites", apb_log.size(), 3);
    if (apb_log.size() == 3) begin
      chk("C_ctrl_addr", apb_log[2].a, 'h00);
      chk("C_ctrl_data", apb_log[2].d, 'h0);
    end
    data_out = 32'h0BAD_F00D; num_of_errors = 2'd3; operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    tick();
    chk("C_rsp_data", last_rsp_data, 32'h0BAD_F00D);

    // Reset during the second write's ACCESS cycle.
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    chk("E_in_access", (m_state == M_BUS) && (m_phase == 1) && (m_q.size() == 2), 1'b1);
    clear_obs();
    rst = 1'b0;
    tick();
    chk("E_psel_reset", last_psel, 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("E_no_rsp", rsp_count, 0);
    chk("E_no_apb", psel_cycles, 0);

    // Both requesters held valid: strict alternation starting at 0.
    clear_obs();
    req_valid = 2'b11;
    set_req0(2'b01, 2'b00, 32'h77, 32'h0);
    begin
      int guard;
      guard = 0;
      while (grant_log.size() < 3 && guard < 300) begin
        operation_done = (m_state == M_WAIT);
        data_out = $urandom;
        tick();
        guard++;
      end
    end
    req_valid = '0;
    operation_done = 1'b0;
    finish_job("D_finish");
    chk("D_ngrants", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      chk("D_grant0", grant_log[0], 0);
      chk("D_grant1", grant_log[1], 1);
      chk("D_grant2", grant_log[2], 0);
    end

    // No operation_done at all while waiting.
    clear_obs();
    req_valid = 2'b01;
    set_req0(2'b00, 2'b00, 32'h11, 32'h0);
    tick();
    req_valid = '0;
    wait_state(M_WAIT, 20, "F_wait");
    data_out = 32'hFFFF_FFFF; num_of_errors = 2'd3;
    k_at = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (rsp_count > 0) begin
        k_at = k;
        break;
      end
    end
`ifdef ECC_JOB_SCHEDULER_TIMEOUT_EN
    chk("F_timeout_latency", k_at, TO + 1);
    chk("F_timeout_flag", last_rsp_to, 1'b1);
    chk("F_timeout_data", last_rsp_data, 32'h0);
    chk("F_timeout_err", last_rsp_err, 2'd0);
`else
    chk("F_no_rsp", rsp_count, 0);
    chk("F_still_wait", k_at, 0);
`endif
    finish_job("F_finish");

    // Randomized traffic with withdrawals, stray done pulses and occasional resets.
    for (int it = 0; it < 3000; it++) begin
      rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
        end
        req_data[i*DW +: DW]  = $urandom;
        req_noise[i*DW +: DW] = $urandom;
      end
      req_ctrl       = (2*NR)'($urandom);
      req_width      = (2*NR)'($urandom);
      operation_done = ($urandom_range(0, 3) == 0);
      data_out       = $urandom;
      num_of_errors  = 2'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b1;
    req_valid = '0;
    finish_job("R_finish");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_job_scheduler.md
ECC_JOB_SCHEDULER -- requirements
Module: ecc_job_scheduler

Interface
REQ-001 SHALL have parameter AMBA_WORD, default 32, APB data width.
REQ-002 SHALL have parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, ECC engine data width.
REQ-004 SHALL have parameter NUM_REQ, default 2, number of requesters, legal range 2..4.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT-state limit.
REQ-006 Port clk  input  1  single clock, all logic on rising edge.
REQ-007 Port rst  input  1  asynchronous, active-low reset.
REQ-008 Port req_valid  input  NUM_REQ  per-requester job request.
REQ-009 Port req_ready  output  NUM_REQ  one-hot one-cycle job-accept pulse.
REQ-010 Port req_ctrl  input  2*NUM_REQ  per-requester mode: 00 encode, 01 decode, 10 full channel.
REQ-011 Port req_width  input  2*NUM_REQ  per-requester codeword width code.
REQ-012 Port req_data  input  DATA_WIDTH*NUM_REQ  per-requester data word; req_noise same width, noise word.
REQ-013 Ports PSEL, PENABLE, PWRITE  output  1 each; PADDR  output  AMBA_ADDR_WIDTH; PWDATA  output  AMBA_WORD: APB master to engine.
REQ-014 Ports operation_done  input  1; data_out  input  DATA_WIDTH; num_of_errors  input  2: engine results.
REQ-015 Ports rsp_valid  output  1; rsp_id  output  $clog2(NUM_REQ); rsp_data  output  DATA_WIDTH; rsp_errors  output  2; rsp_timeout  output  1.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, ACCESS, WAIT, RESP.
REQ-017 In IDLE with any req_valid high, SHALL grant round-robin starting after last granted index, pulse req_ready[grant] that cycle, latch that requester's ctrl/width/data/noise and id, go to SETUP.
REQ-018 Latched ctrl 2'b11 SHALL be replaced by 2'b00.
REQ-019 Write sequence SHALL be DATA_IN (0x04), CODEWORD_WIDTH (0x08), NOISE (0x0C, only when ctrl=10), CTRL (0x00) last; PWDATA zero-extended.
REQ-020 Each write SHALL be one SETUP cycle (PSEL=1, PENABLE=0, PWRITE=1) then one ACCESS cycle (PSEL=1, PENABLE=1); next write's SETUP follows immediately; after CTRL ACCESS go to WAIT.
REQ-021 Outside SETUP/ACCESS, PSEL, PENABLE, PWRITE SHALL be 0 and PADDR, PWDATA 0.
REQ-022 In WAIT, operation_done high SHALL capture data_out and num_of_errors and go to RESP next cycle.
REQ-023 RESP SHALL last one cycle: rsp_valid=1 with rsp_id, captured rsp_data/rsp_errors, then IDLE; new grant possible the cycle after RESP.
REQ-024 Accept-to-first-SETUP latency 1 cycle; write phase 6 cycles (modes 00/01) or 8 cycles (mode 10).
REQ-025 operation_done outside WAIT SHALL be ignored.
REQ-026 Requests arriving while not IDLE SHALL wait; req_valid deassertion before req_ready SHALL withdraw the request without side effects.
REQ-027 All requesters valid continuously SHALL yield strict alternation 0,1,..,NUM_REQ-1,0.
REQ-028 rsp_data, rsp_errors, rsp_id SHALL hold last response values until next RESP.

Reset
REQ-029 rst low SHALL immediately force IDLE, all outputs 0, last-grant pointer NUM_REQ-1 (requester 0 wins first), timeout counter 0.
REQ-030 Reset mid-job SHALL drop the job with no rsp_valid and no further APB activity.

Configuration
REQ-031 Macro ECC_JOB_SCHEDULER_TIMEOUT_EN defined: WAIT counter increments per cycle, clears on entering WAIT; reaching TIMEOUT_CYCLES without operation_done SHALL go to RESP with rsp_timeout=1, rsp_data=0, rsp_errors=0.
REQ-032 Macro undefined: no counter logic, WAIT indefinite, rsp_timeout tied 0.

Verification
REQ-033 Reset then req_valid=01, ctrl=00, width=01, data=0x5A -> req_ready=01 same cycle; APB writes 0x04=0x5A, 0x08=1, 0x00=0 over 6 cycles; done pulse -> rsp_valid next cycle, rsp_id=0, rsp_data=data_out.
REQ-034 ctrl=10, noise=0x3 -> 4 writes in order 0x04, 0x08, 0x0C=0x3, 0x00=2, 8 cycles; num_of_errors=2 -> rsp_errors=2.
REQ-035 req_valid=11 held for 3 jobs -> grants 0,1,0; no APB overlap.
REQ-036 rst low during second write ACCESS -> PSEL=0 immediately, no rsp_valid, next job starts with grant 0.
REQ-037 TIMEOUT_EN defined, TIMEOUT_CYCLES=64, no done -> rsp_valid, rsp_timeout=1 after 64 WAIT cycles; undefined -> FSM stays WAIT for 200 cycles.
REQ-038 ctrl=11 -> CTRL write PWDATA=0; operation_done pulsed during SETUP -> ignored, FSM waits for later done.
